cam_cfg_sequencer: RTL
======================

CAM_CFG_SEQUENCER -- requirements
Module: cam_cfg_sequencer

Interface
REQ-001 SHALL have parameter IDX_W, default 10, width of the table index.
REQ-002 SHALL have parameter DELAY_CYC, default 1000000, clock cycles waited on a delay entry.
REQ-003 SHALL have parameter MAX_RETRY, default 3, re-issues allowed per entry after a bus error.
REQ-004 SHALL have port clk  in  1  the single clock.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port start  in  1  one-cycle pulse that begins a configuration pass.
REQ-007 SHALL have port lut_index  out  IDX_W  current table entry.
REQ-008 SHALL have port lut_data  in  32  entry as {dev_addr[7:0], reg_addr[15:0], value[7:0]}, combinational from lut_index.
REQ-009 SHALL have port i2c_req  out  1  request to the bus master.
REQ-010 SHALL have port i2c_rd  out  1  1 = read op, 0 = write op.
REQ-011 SHALL have port i2c_dev  out  8  device address.
REQ-012 SHALL have port i2c_addr  out  16  register address.
REQ-013 SHALL have port i2c_wdata  out  8  write data.
REQ-014 SHALL have port i2c_done  in  1  one-cycle completion pulse.
REQ-015 SHALL have port i2c_err  in  1  NACK flag, valid with i2c_done.
REQ-016 SHALL have port i2c_rdata  in  8  read data, valid with i2c_done.
REQ-017 SHALL have port busy  out  1  pass in progress.
REQ-018 SHALL have port cfg_done  out  1  level, set when the pass completes.
REQ-019 SHALL have port cfg_err  out  1  level, set when the pass aborts.
REQ-020 SHALL have port err_index  out  IDX_W  entry that caused the abort.

Function
REQ-021 SHALL use states IDLE, FETCH, DECODE, ISSUE, WAIT, CHECK, DELAY, DONE and ERROR.
- IDLE + start -> FETCH, with lut_index=0, retry=0, cfg_done=0, cfg_err=0.
REQ-022 SHALL register lut_data in FETCH, one cycle after lut_index changes, then enter DECODE.
REQ-023 SHALL decode the entry by dev_addr:
- 8'hFF -> DONE.
- 8'hFE -> DELAY.
- otherwise -> ISSUE with i2c_rd=0.
REQ-024 SHALL hold i2c_req high with i2c_dev, i2c_addr and i2c_wdata stable from ISSUE until i2c_done, then drop i2c_req the cycle after i2c_done.
REQ-025 SHALL ignore i2c_done while i2c_req is low.
REQ-026 SHALL, on i2c_done with i2c_err=0 after a write, advance lut_index by 1, clear retry and return to FETCH.
REQ-027 SHALL, on i2c_done with i2c_err=1, re-ISSUE the same entry and increment retry if retry<MAX_RETRY; otherwise enter ERROR with err_index=lut_index.
REQ-028 SHALL count DELAY_CYC cycles in DELAY, then advance lut_index and enter FETCH; DELAY_CYC=0 SHALL act as 1.
REQ-029 SHALL enter ERROR with err_index=2^IDX_W-1 if lut_index reaches 2^IDX_W-1 without reading an end marker; lut_index SHALL never wrap.
REQ-030 DONE SHALL set cfg_done=1 and ERROR SHALL set cfg_err=1; both states SHALL return to IDLE the next cycle, and the flag SHALL hold until the next start.
REQ-031 SHALL assert busy in every state except IDLE.
REQ-032 SHALL ignore start while busy=1.

Reset
REQ-033 SHALL, while rst=1, force state=IDLE and drive lut_index, retry, i2c_req, i2c_rd, i2c_dev, i2c_addr, i2c_wdata, busy, cfg_done, cfg_err and err_index to 0.
REQ-034 SHALL, on rst mid-transaction, drop i2c_req immediately and discard any i2c_done arriving after reset.

Configuration
REQ-035 SHALL compile readback verification in when macro CAM_CFG_READBACK_EN is defined.
- With the macro: after a successful write, re-issue the same address with i2c_rd=1.
- In CHECK: i2c_rdata==value advances lut_index; a mismatch enters ERROR.
- A NACK on the read follows the REQ-027 retry rule.
REQ-036 SHALL, without CAM_CFG_READBACK_EN, never assert i2c_rd, never enter CHECK, and ignore i2c_rdata.

Verification
REQ-037 Table {78_3103_11, 78_3008_82, FF_FFFFFF}, i2c_done 5 cycles after each req -> two writes in order, cfg_done=1, busy=0, lut_index=2.
REQ-038 Entry 1 = FE_000000, DELAY_CYC=20 -> no i2c_req for 20 cycles after entry 0 completes, then entry 2 is issued.
REQ-039 Entry 0 NACKed twice, MAX_RETRY=3 -> 3 identical requests, then the pass continues; four NACKs -> cfg_err=1, err_index=0.
REQ-040 With CAM_CFG_READBACK_EN, write 0x3017 value FF, readback returns FE -> cfg_err=1, err_index=index of 0x3017 entry.
REQ-041 rst asserted while i2c_req=1, i2c_done pulses 2 cycles later -> outputs stay at reset values; a later start restarts at index 0.
REQ-042 start pulsed during busy, and table without an end marker at IDX_W=4 -> pass not restarted; cfg_err=1, err_index=15.

Source files
------------

// File: rtl/cam_cfg_sequencer.sv
// cam_cfg_sequencer
//   Walks a camera configuration table and turns each entry into an I2C
//   register write. Entry layout: {dev_addr[7:0], reg_addr[15:0], value[7:0]}.
//   dev_addr 8'hFF ends the pass, 8'hFE waits DELAY_CYC cycles, anything
//   else is written to the bus master. NACKed ops are re-issued up to
//   MAX_RETRY times before the pass aborts.
//
//   Optional feature: define CAM_CFG_READBACK_EN to read each register back
//   after writing it and abort the pass on a value mismatch.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   start            one-cycle pulse, begins a pass (ignored while busy)
//   lut_index        table entry being fetched
//   lut_data         table entry, combinational from lut_index
//   i2c_req/rd/dev/addr/wdata   request to the bus master, held until done
//   i2c_done/err/rdata          completion pulse, NACK flag, read data
//   busy             pass in progress
//   cfg_done/cfg_err level status of the last pass, cleared by start
//   err_index        entry that caused the abort
module cam_cfg_sequencer #(
   parameter int IDX_W     = 10,
   parameter int DELAY_CYC = 1000000,
   parameter int MAX_RETRY = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [IDX_W-1:0] lut_index,
   input  logic [31:0]      lut_data,
   output logic             i2c_req,
   output logic             i2c_rd,
   output logic [7:0]       i2c_dev,
   output logic [15:0]      i2c_addr,
   output logic [7:0]       i2c_wdata,
   input  logic             i2c_done,
   input  logic             i2c_err,
   input  logic [7:0]       i2c_rdata,
   output logic             busy,
   output logic             cfg_done,
   output logic             cfg_err,
   output logic [IDX_W-1:0] err_index
);

   // a zero-length delay still spends one cycle in DELAY
   localparam int DLY = (DELAY_CYC < 1) ? 1 : DELAY_CYC;
   localparam int CW  = $clog2(DLY + 1);
   localparam int RW  = $clog2(MAX_RETRY + 2);
   localparam logic [IDX_W-1:0] LAST = '1;

   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, ISSUE, WAIT, CHECK, DELAY, DONE, ERROR
   } state_t;

   state_t           state, nxt_state;
   logic [IDX_W-1:0] nxt_index, nxt_err_index;
   logic [RW-1:0]    retry, nxt_retry;
   logic [31:0]      entry, nxt_entry;
   logic [CW-1:0]    dly_cnt, nxt_dly_cnt;
   logic             nxt_req, nxt_rd, nxt_cfg_done, nxt_cfg_err;
   logic [7:0]       nxt_dev, nxt_wdata;
   logic [15:0]      nxt_addr;

`ifdef CAM_CFG_READBACK_EN
   logic [7:0]       rdata_q, nxt_rdata;
`else
   logic             unused_rdata;
   assign unused_rdata = ^i2c_rdata;
`endif

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         lut_index <= '0;
         retry     <= '0;
         entry     <= '0;
         dly_cnt   <= '0;
         i2c_req   <= 1'b0;
         i2c_rd    <= 1'b0;
         i2c_dev   <= '0;
         i2c_addr  <= '0;
         i2c_wdata <= '0;
         cfg_done  <= 1'b0;
         cfg_err   <= 1'b0;
         err_index <= '0;
`ifdef CAM_CFG_READBACK_EN
         rdata_q   <= '0;
`endif
      end else begin
         state     <= nxt_state;
         lut_index <= nxt_index;
         retry     <= nxt_retry;
         entry     <= nxt_entry;
         dly_cnt   <= nxt_dly_cnt;
         i2c_req   <= nxt_req;
         i2c_rd    <= nxt_rd;
         i2c_dev   <= nxt_dev;
         i2c_addr  <= nxt_addr;
         i2c_wdata <= nxt_wdata;
         cfg_done  <= nxt_cfg_done;
         cfg_err   <= nxt_cfg_err;
         err_index <= nxt_err_index;
`ifdef CAM_CFG_READBACK_EN
         rdata_q   <= nxt_rdata;
`endif
      end
   end

   always_comb begin
      nxt_state     = state;
      nxt_index     = lut_index;
      nxt_retry     = retry;
      nxt_entry     = entry;
      nxt_dly_cnt   = dly_cnt;
      nxt_req       = i2c_req;
      nxt_rd        = i2c_rd;
      nxt_dev       = i2c_dev;
      nxt_addr      = i2c_addr;
      nxt_wdata     = i2c_wdata;
      nxt_cfg_done  = cfg_done;
      nxt_cfg_err   = cfg_err;
      nxt_err_index = err_index;
`ifdef CAM_CFG_READBACK_EN
      nxt_rdata     = rdata_q;
`endif
      case (state)
         IDLE: if (start) begin
            nxt_index    = '0;
            nxt_retry    = '0;
            nxt_cfg_done = 1'b0;
            nxt_cfg_err  = 1'b0;
            nxt_state    = FETCH;
         end
         FETCH: begin
            nxt_entry = lut_data;
            nxt_state = DECODE;
         end
         DECODE: begin
            if (entry[31:24] == 8'hFF) nxt_state = DONE;
            else if (lut_index == LAST) begin
               // table exhausted without an end marker; index never wraps
               nxt_err_index = LAST;
               nxt_state     = ERROR;
            end else if (entry[31:24] == 8'hFE) begin
               nxt_dly_cnt = '0;
               nxt_state   = DELAY;
            end else begin
               nxt_rd    = 1'b0;
               nxt_state = ISSUE;
            end
         end
         ISSUE: begin
            nxt_req   = 1'b1;
            nxt_dev   = entry[31:24];
            nxt_addr  = entry[23:8];
            nxt_wdata = entry[7:0];
            nxt_state = WAIT;
         end
         WAIT: if (i2c_req && i2c_done) begin
            nxt_req = 1'b0;
            if (i2c_err) begin
               if (retry < RW'(MAX_RETRY)) begin
                  nxt_retry = retry + 1'b1;
                  nxt_state = ISSUE;
               end else begin
                  nxt_err_index = lut_index;
                  nxt_state     = ERROR;
               end
            end else begin
`ifdef CAM_CFG_READBACK_EN
               if (!i2c_rd) begin
                  nxt_rd    = 1'b1;
                  nxt_state = ISSUE;
               end else begin
                  nxt_rdata = i2c_rdata;
                  nxt_state = CHECK;
               end
`else
               nxt_index = lut_index + 1'b1;
               nxt_retry = '0;
               nxt_state = FETCH;
`endif
            end
         end
`ifdef CAM_CFG_READBACK_EN
         CHECK: begin
            if (rdata_q == entry[7:0]) begin
               nxt_index = lut_index + 1'b1;
               nxt_retry = '0;
               nxt_state = FETCH;
            end else begin
               nxt_err_index = lut_index;
               nxt_state     = ERROR;
            end
         end
`endif
         DELAY: begin
            nxt_dly_cnt = dly_cnt + 1'b1;
            if (dly_cnt == CW'(DLY - 1)) begin
               nxt_index = lut_index + 1'b1;
               nxt_retry = '0;
               nxt_state = FETCH;
            end
         end
         DONE: begin
            nxt_cfg_done = 1'b1;
            nxt_state    = IDLE;
         end
         ERROR: begin
            nxt_cfg_err = 1'b1;
            nxt_state   = IDLE;
         end
         default: nxt_state = IDLE;
      endcase
   end

endmodule
